// File: rtl/pack_rx_fifo.sv
// pack_rx_fifo: receive packet FIFO with ENDP-derived tlast/tkeep and guaranteed packet termination.
// Optional drop/watermark statistics are built when PACK_RX_FIFO_STATS_EN is defined.
module pack_rx_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_NUM_LANES = 4,
  parameter int DEPTH = 8,
  parameter logic [7:0] ENDP = 8'hFD,
  localparam int L = MAX_NUM_LANES,
  localparam int W = MAX_NUM_LANES * DATA_WIDTH,
  localparam int KW = W / 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            phy_link_up_i,
  input  logic            wr_en_i,
  input  logic [W-1:0]    wr_data_i,
  input  logic [L-1:0]    wr_valid_i,
  input  logic [4*L-1:0]  wr_k_i,
  input  logic [2*L-1:0]  wr_sync_header_i,
  output logic [W-1:0]    m_axis_tdata,
  output logic [KW-1:0]   m_axis_tkeep,
  output logic            m_axis_tvalid,
  input  logic            m_axis_tready,
  output logic            m_axis_tlast,
  output logic [6*L:0]    m_axis_tuser,
  output logic [CW-1:0]   fill_level_o,
  output logic            overflow_o,
  output logic [15:0]     drop_count_o,
  output logic [CW-1:0]   max_level_o
);
  typedef enum logic {ST_PASS, ST_DROP} state_t;
  state_t r_state;
  logic [W-1:0]   r_data  [DEPTH];
  logic [KW-1:0]  r_keep  [DEPTH];
  logic [6*L-1:0] r_user  [DEPTH];
  logic [L-1:0]   r_valid [DEPTH];
  logic           r_last  [DEPTH];
  logic           r_err   [DEPTH];
  logic [AW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic           r_overflow;
  logic [KW-1:0]  w_keep;
  logic           w_seen, w_wr, w_trunc, w_drop, w_pop, w_full;
  // A byte is kept only if no ENDP appears in any lower byte, so bytes 0..e stay enabled.
  always_comb begin
    w_seen = 1'b0;
    w_keep = '0;
    for (int b = 0; b < KW; b++) begin
      w_keep[b] = !w_seen;
      w_seen = w_seen | (wr_data_i[8*b +: 8] == ENDP);
    end
  end
  assign w_full  = r_count == CW'(DEPTH);
  assign w_wr    = phy_link_up_i && wr_en_i && r_state == ST_PASS && !w_full;
  assign w_trunc = w_wr && !w_seen && r_count == CW'(DEPTH - 1);
  assign w_drop  = phy_link_up_i && wr_en_i && (r_state == ST_DROP || w_full);
  assign w_pop   = m_axis_tvalid && m_axis_tready;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
        r_keep[i] <= '0;
        r_user[i] <= '0;
        r_valid[i] <= '0;
        r_last[i] <= 1'b0;
        r_err[i] <= 1'b0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count <= '0;
      r_overflow <= 1'b0;
      r_state <= ST_PASS;
    end else if (!phy_link_up_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count <= '0;
      r_state <= ST_PASS;
    end else begin
      if (w_wr) begin
        r_data[r_wr_ptr] <= wr_data_i;
        r_keep[r_wr_ptr] <= w_trunc ? '1 : w_keep;
        r_user[r_wr_ptr] <= {wr_sync_header_i, wr_k_i};
        r_valid[r_wr_ptr] <= wr_valid_i;
        r_last[r_wr_ptr] <= w_seen || w_trunc;
        r_err[r_wr_ptr] <= w_trunc;
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + {{(CW-1){1'b0}}, w_wr} - {{(CW-1){1'b0}}, w_pop};
      if (w_drop || w_trunc) r_overflow <= 1'b1;
      if (w_drop) r_state <= w_seen ? ST_PASS : ST_DROP;
      else if (w_trunc) r_state <= ST_DROP;
    end
  end
  assign m_axis_tdata  = r_data[r_rd_ptr];
  assign m_axis_tkeep  = r_keep[r_rd_ptr];
  assign m_axis_tlast  = r_last[r_rd_ptr];
  assign m_axis_tuser  = {r_err[r_rd_ptr], r_user[r_rd_ptr]};
  assign m_axis_tvalid = r_count != '0;
  assign fill_level_o  = r_count;
  assign overflow_o    = r_overflow;
`ifdef PACK_RX_FIFO_STATS_EN
  logic [15:0]   r_drop_count;
  logic [CW-1:0] r_max_level;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_drop_count <= '0;
      r_max_level <= '0;
    end else begin
      if (w_drop && r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
      if (r_count > r_max_level) r_max_level <= r_count;
    end
  end
  assign drop_count_o = r_drop_count;
  assign max_level_o  = r_max_level;
`else
  assign drop_count_o = '0;
  assign max_level_o  = '0;
`endif
endmodule

// File: tb/tb_pack_rx_fifo.sv
// tb_pack_rx_fifo: directed self-checking bench for pack_rx_fifo (W=128, DEPTH=8, ENDP=8'hFD).
module tb_pack_rx_fifo;
  logic clk_i = 1'b0, rst_ni = 1'b0, phy_link_up_i = 1'b1, wr_en_i = 1'b0, m_axis_tready = 1'b0;
  logic [127:0] wr_data_i = '0;
  logic [3:0]   wr_valid_i = 4'hF;
  logic [15:0]  wr_k_i = '0;
  logic [7:0]   wr_sync_header_i = '0;
  logic [127:0] m_axis_tdata;
  logic [15:0]  m_axis_tkeep;
  logic         m_axis_tvalid, m_axis_tlast, overflow_o;
  logic [24:0]  m_axis_tuser;
  logic [3:0]   fill_level_o, max_level_o;
  logic [15:0]  drop_count_o;
  int n_vec = 0, n_bad = 0;
  logic [127:0] q[$];
  pack_rx_fifo dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .phy_link_up_i(phy_link_up_i), .wr_en_i(wr_en_i),
    .wr_data_i(wr_data_i), .wr_valid_i(wr_valid_i), .wr_k_i(wr_k_i),
    .wr_sync_header_i(wr_sync_header_i), .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser), .fill_level_o(fill_level_o),
    .overflow_o(overflow_o), .drop_count_o(drop_count_o), .max_level_o(max_level_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk_i);
    #1;
  endtask
  task automatic wr(input logic [127:0] d);
    wr_en_i = 1'b1;
    wr_data_i = d;
    step;
    wr_en_i = 1'b0;
  endtask
  // Word n replicated in every byte; b >= 0 places ENDP at byte b.
  function automatic logic [127:0] wd(input int n, input int b);
    logic [127:0] d;
    d = {16{n[7:0]}};
    if (b >= 0) d[8*b +: 8] = 8'hFD;
    return d;
  endfunction
  initial begin
    repeat (2) step;
    rst_ni = 1'b1;
    step;
    // 1: reset asserted mid-traffic
    for (int k = 1; k <= 3; k++) wr(wd(k, -1));
    chk("pre_reset_fill", fill_level_o, 3);
    #2 rst_ni = 1'b0;
    #1;
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_fill", fill_level_o, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_ovf", overflow_o, 0);
    chk("rst_drop", drop_count_o, 0);
    step;
    rst_ni = 1'b1;
    step;
    // 2: single packet with ENDP at byte 5
    m_axis_tready = 1'b1;
    wr_k_i = 16'h000F;
    wr_sync_header_i = 8'h5A;
    wr(wd(9, 5));
    chk("t2_tvalid", m_axis_tvalid, 1);
    chk("t2_tlast", m_axis_tlast, 1);
    chk("t2_tkeep", m_axis_tkeep, 16'h003F);
    chk("t2_tuser", m_axis_tuser, {1'b0, 8'h5A, 16'h000F});
    chk("t2_tdata", m_axis_tdata, wd(9, 5));
    wr_k_i = '0;
    wr_sync_header_i = '0;
    step;
    chk("t2_empty", m_axis_tvalid, 0);
    // 3: overflow truncation and drop
    m_axis_tready = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      wr(wd(i, -1));
      if (i == 7) begin
        chk("t3_fill7", fill_level_o, 7);
        chk("t3_ovf7", overflow_o, 0);
      end
      if (i == 8) begin
        chk("t3_fill8", fill_level_o, 8);
        chk("t3_ovf8", overflow_o, 1);
      end
    end
    wr(wd(13, 0));
    chk("t3_fill_end", fill_level_o, 8);
`ifdef PACK_RX_FIFO_STATS_EN
    chk("t3_drops", drop_count_o, 5);
`else
    chk("t3_drops", drop_count_o, 0);
`endif
    m_axis_tready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("t3_tdata", m_axis_tdata, wd(i, -1));
      chk("t3_tlast", m_axis_tlast, i == 8);
      chk("t3_err", m_axis_tuser[24], i == 8);
      chk("t3_tkeep", m_axis_tkeep, 16'hFFFF);
      step;
    end
    chk("t3_drained", m_axis_tvalid, 0);
`ifdef PACK_RX_FIFO_STATS_EN
    chk("t3_maxlvl", max_level_o, 8);
`else
    chk("t3_maxlvl", max_level_o, 0);
`endif
    wr(wd(50, 2));
    chk("t3_pass_tvalid", m_axis_tvalid, 1);
    chk("t3_pass_tkeep", m_axis_tkeep, 16'h0007);
    chk("t3_pass_tlast", m_axis_tlast, 1);
    step;
    chk("t3_pass_empty", m_axis_tvalid, 0);
    // 4: simultaneous write and pop at fill 3, across pointer wrap
    m_axis_tready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wr(wd(20 + k, -1));
      q.push_back(wd(20 + k, -1));
    end
    m_axis_tready = 1'b1;
    wr_en_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wr_data_i = wd(23 + i, -1);
      chk("t4_tdata", m_axis_tdata, q[0]);
      chk("t4_fill", fill_level_o, 3);
      step;
      void'(q.pop_front());
      q.push_back(wd(23 + i, -1));
    end
    wr_en_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t4_drain", m_axis_tdata, q[0]);
      step;
      void'(q.pop_front());
    end
    chk("t4_empty", m_axis_tvalid, 0);
    // 5: link down flush
    m_axis_tready = 1'b0;
    for (int k = 0; k < 5; k++) wr(wd(60 + k, -1));
    chk("t5_fill5", fill_level_o, 5);
    wr_en_i = 1'b1;
    wr_data_i = wd(70, -1);
    phy_link_up_i = 1'b0;
    step;
    chk("t5_tvalid", m_axis_tvalid, 0);
    chk("t5_fill0", fill_level_o, 0);
    step;
    chk("t5_fill0b", fill_level_o, 0);
    phy_link_up_i = 1'b1;
    wr_en_i = 1'b0;
    step;
    chk("t5_nostore", m_axis_tvalid, 0);
    chk("t5_ovf_kept", overflow_o, 1);
    wr(wd(77, 3));
    chk("t5_fill1", fill_level_o, 1);
    chk("t5_tdata", m_axis_tdata, wd(77, 3));
    chk("t5_tkeep", m_axis_tkeep, 16'h000F);
    chk("t5_tlast", m_axis_tlast, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
